// File: rtl/parity_sweep_checker.sv
// ---------------------------------------------------------------------------
// parity_sweep_checker
//
// Exhaustive stimulus engine and checker for WIDTH-input parity gates.
// A pulse on start sweeps vec through every value 0 .. 2^WIDTH-1. Each value
// is held for DWELL cycles. The UUT response on dut_f is compared against an
// internal golden parity on the last cycle of each dwell. The golden parity
// is XNOR when mode=0 and XOR when mode=1, and mode is latched at start.
// The block reports a verdict, a mismatch count and the first failing vector.
//
// Parameters:
//   WIDTH  number of UUT inputs (1..16)
//   DWELL  cycles each vector is held (1..255)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a sweep (honoured in IDLE or DONE)
//   abort          in   cancel a sweep (honoured in RUN)
//   mode           in   golden select: 0 = XNOR, 1 = XOR
//   dut_f          in   UUT output
//   vec            out  stimulus driven to the UUT
//   busy           out  high while sweeping
//   done           out  high after a completed sweep, until next start/reset
//   pass           out  valid with done; 1 when no mismatches were seen
//   err_cnt        out  number of mismatching vectors
//   first_fail     out  first mismatching vector
//   first_fail_vld out  first_fail holds a valid value
// ---------------------------------------------------------------------------
module parity_sweep_checker #(
  parameter int WIDTH = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             dut_f,
  output logic [WIDTH-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_vld
);

  // The dwell counter needs at least one bit even when DWELL is 1.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] dwell_cnt;
  logic          mode_q;
  logic          golden;
  logic          mismatch;
  logic          sample;
  logic          last_vec;

  // Golden value and the sample strobe for the vector currently driven.
  always_comb begin
    golden   = mode_q ? (^vec) : (~^vec);
    mismatch = (dut_f != golden);
    sample   = (dwell_cnt == LAST_DWELL);
    last_vec = (vec == '1);
  end

  // Sweep controller. In RUN, abort takes priority over the final sample so
  // an aborted sweep never reports done. pass is computed from the count
  // including the final sample, since err_cnt updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      dwell_cnt      <= '0;
      mode_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            vec            <= '0;
            dwell_cnt      <= '0;
            mode_q         <= mode;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            // Partial error results stay visible for debug.
            state     <= IDLE;
            vec       <= '0;
            dwell_cnt <= '0;
            busy      <= 1'b0;
          end else if (sample) begin
            if (mismatch) begin
              err_cnt <= err_cnt + 1'b1;
              if (!first_fail_vld) begin
                first_fail     <= vec;
                first_fail_vld <= 1'b1;
              end
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt == '0) && !mismatch;
            end else begin
              vec       <= vec + 1'b1;
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_sweep_checker
//
// Bench for parity_sweep_checker. Two instances are exercised one after the
// other: dut_a (WIDTH=3, DWELL=4) and dut_b (WIDTH=4, DWELL=1). The UUT is
// modelled as a truth table tbl indexed by vec, so correct, stuck and
// randomly faulty gates are all just different table contents. Expected
// verdicts come from counting table entries that disagree with the parity
// rule for the latched mode.
// ---------------------------------------------------------------------------
module tb_parity_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] tbl = '0;

  logic        dut_f_a, dut_f_b;
  logic [2:0]  vec_a, first_fail_a;
  logic [3:0]  err_cnt_a;
  logic        busy_a, done_a, pass_a, first_fail_vld_a;
  logic [3:0]  vec_b, first_fail_b;
  logic [4:0]  err_cnt_b;
  logic        busy_b, done_b, pass_b, first_fail_vld_b;

  int checks = 0;
  int errors = 0;

  // Selects which instance the generic tasks observe.
  logic        sel = 1'b0;
  logic        busy_s, done_s, pass_s, vld_s;
  logic [4:0]  err_s;
  logic [3:0]  vec_s, ff_s;

  always #5 clk = ~clk;

  // Combinational UUT models: each instance reads the same truth table.
  assign dut_f_a = tbl[{1'b0, vec_a}];
  assign dut_f_b = tbl[vec_b];

  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign vld_s  = sel ? first_fail_vld_b : first_fail_vld_a;
  assign err_s  = sel ? err_cnt_b : {1'b0, err_cnt_a};
  assign vec_s  = sel ? vec_b : {1'b0, vec_a};
  assign ff_s   = sel ? first_fail_b : {1'b0, first_fail_a};

  parity_sweep_checker #(.WIDTH(3), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .mode(mode),
    .dut_f(dut_f_a), .vec(vec_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_cnt_a), .first_fail(first_fail_a),
    .first_fail_vld(first_fail_vld_a)
  );

  parity_sweep_checker #(.WIDTH(4), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .mode(mode),
    .dut_f(dut_f_b), .vec(vec_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_cnt_b), .first_fail(first_fail_b),
    .first_fail_vld(first_fail_vld_b)
  );

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start on the selected instance; optionally abort in the same
  // cycle. Returns at the falling edge of the first busy cycle.
  task automatic applyStimulus(input bit which, input bit m, input bit with_abort);
    @(negedge clk);
    mode  = m;
    abort = with_abort;
    if (which) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
  endtask

  // Reference: how many of the first nvec vectors the table gets wrong for
  // the given golden mode, and the lowest such vector.
  task automatic model(input int nvec, input bit m, output int errs,
                       output int first, output bit vld);
    bit odd, gold;
    errs = 0; first = 0; vld = 1'b0;
    for (int v = 0; v < nvec; v++) begin
      odd  = ($countones(v) % 2) == 1;
      gold = m ? odd : !odd;
      if (tbl[v] != gold) begin
        if (!vld) begin
          first = v;
          vld   = 1'b1;
        end
        errs++;
      end
    end
  endtask

  // Follows a sweep from the first busy cycle, checking that each vector is
  // held for dwell cycles, and returns the number of busy cycles seen.
  task automatic watchSweep(input int dwell, input bit toggle, output int n);
    int bad;
    n = 0;
    bad = 0;
    while (busy_s && n < 2000) begin
      if (vec_s != 4'(n / dwell)) bad++;
      if (toggle) mode = ~mode;
      n++;
      @(negedge clk);
    end
    checkOutput("vec_sequence_bad_cycles", bad, 0);
  endtask

  // Full sweep on the selected instance with verdict checks.
  task automatic fullSweep(input string name, input bit which, input int w,
                           input int dwell, input bit m, input bit toggle,
                           input bit with_abort);
    int n, e, f;
    bit vld;
    sel = which;
    applyStimulus(which, m, with_abort);
    checkOutput({name, "_busy_start"}, busy_s, 1);
    watchSweep(dwell, toggle, n);
    model(2 ** w, m, e, f, vld);
    checkOutput({name, "_busy_cycles"}, n, (2 ** w) * dwell);
    checkOutput({name, "_done"}, done_s, 1);
    checkOutput({name, "_pass"}, pass_s, (e == 0));
    checkOutput({name, "_err_cnt"}, err_s, e);
    checkOutput({name, "_ff_vld"}, vld_s, vld);
    if (vld) checkOutput({name, "_first_fail"}, ff_s, f);
    checkOutput({name, "_vec_last"}, vec_s, (2 ** w) - 1);
  endtask

  initial begin
    int n, e, f;
    bit vld, rm;

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    checkOutput("reset_a_outputs",
      {busy_a, done_a, pass_a, err_cnt_a, first_fail_a, first_fail_vld_a, vec_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort_a_outputs",
      {busy_a, done_a, pass_a, err_cnt_a, first_fail_a, first_fail_vld_a, vec_a}, 0);
    checkOutput("idle_b_outputs",
      {busy_b, done_b, pass_b, err_cnt_b, first_fail_b, first_fail_vld_b, vec_b}, 0);

    // Correct XNOR gate, mode 0.
    for (int v = 0; v < 16; v++) tbl[v] = ($countones(v) % 2) == 0;
    fullSweep("xnor_ok", 1'b0, 3, 4, 1'b0, 1'b0, 1'b0);

    // Abort while DONE is ignored.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("done_abort_ignored", {done_a, pass_a, busy_a}, 3'b110);

    // Stuck-at-0 gate, mode 0: four even-parity vectors fail.
    tbl = '0;
    fullSweep("stuck0", 1'b0, 3, 4, 1'b0, 1'b0, 1'b0);
    checkOutput("stuck0_err_literal", err_cnt_a, 4);

    // XNOR gate checked in XOR mode with mode toggling mid-sweep.
    for (int v = 0; v < 16; v++) tbl[v] = ($countones(v) % 2) == 0;
    fullSweep("mode_latch", 1'b0, 3, 4, 1'b1, 1'b1, 1'b0);
    checkOutput("mode_latch_err_literal", err_cnt_a, 8);

    // Randomly faulty gates against a random mode.
    for (int i = 0; i < 4; i++) begin
      tbl = 16'($urandom);
      rm  = 1'($urandom_range(1, 0));
      fullSweep("random", 1'b0, 3, 4, rm, 1'b0, 1'b0);
    end

    // Abort on the 10th busy cycle with an ignored start on the 3rd.
    tbl = '0;
    sel = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 1;
    while (n < 10) begin
      start_a = (n == 3);
      @(negedge clk);
      n++;
    end
    start_a = 1'b0;
    checkOutput("abort_vec_before", vec_a, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    model(2, 1'b0, e, f, vld);
    checkOutput("abort_state", {busy_a, done_a, vec_a}, 0);
    checkOutput("abort_partial_err", err_cnt_a, e);
    checkOutput("abort_partial_vld", first_fail_vld_a, vld);
    repeat (3) @(negedge clk);
    checkOutput("abort_stays_idle", {busy_a, done_a}, 0);

    // Restart with start and abort together: start wins, full sweep follows.
    for (int v = 0; v < 16; v++) tbl[v] = ($countones(v) % 2) == 0;
    fullSweep("restart", 1'b0, 3, 4, 1'b0, 1'b0, 1'b1);

    // WIDTH=4, DWELL=1, correct XOR gate, mode 1.
    for (int v = 0; v < 16; v++) tbl[v] = ($countones(v) % 2) == 1;
    fullSweep("b_xor_ok", 1'b1, 4, 1, 1'b1, 1'b0, 1'b0);

    // Random table on the wide instance.
    tbl = 16'($urandom);
    fullSweep("b_random", 1'b1, 4, 1, 1'b1, 1'b0, 1'b0);

    // Reset mid-sweep clears everything at once.
    sel = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("b_busy_before_reset", busy_b, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("b_async_reset",
      {busy_b, done_b, pass_b, err_cnt_b, first_fail_b, first_fail_vld_b, vec_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("b_no_resume",
      {busy_b, done_b, pass_b, err_cnt_b, first_fail_b, first_fail_vld_b, vec_b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
